mem_access_ctrl: RTL and testbench

//  CPU-side initiator for the word-organised data memory (addr/data2/lw_en/sw_en/data_mem).

---
 rtl/mem_access_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// CPU-side initiator for the word-organised data memory. Converts byte-addressed
// LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-index read/write strobes.
// Sub-word stores are done as read-modify-write. Load data is lane-extracted and
// sign/zero-extended.
//
// Optional feature macro: LSU_STATS_EN (adds stat_loads/stat_stores/stat_errs).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_size,     store flag, size (00 B, 01 H, 10 W, 11 illegal),
//   req_unsigned          zero-extend loads when set
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid/rsp_ready   response handshake (valid only in RESP)
//   rsp_rdata, rsp_err    extended load data (0 for stores/errors), error flag
//   mem_addr, mem_wdata   word index and write word to data memory
//   mem_lw_en, mem_sw_en  one-cycle read / write strobes
//   mem_rdata             read word, sampled at the edge ending the READ cycle
//   stat_*                saturating consumed-response counters (LSU_STATS_EN)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_lw_en,
  output logic              mem_sw_en,
  input  logic [31:0]       mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t              state_q;
  logic                req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]         rsp_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_lw_en_q, mem_sw_en_q;
  // Request fields latched at accept
  logic                we_q, uns_q;
  logic [1:0]          size_q, off_q;
  logic [31:0]         wdata_q;
  logic                req_err_d;

  // Misaligned, illegal size, or beyond the memory's word range
  assign req_err_d = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     (req_addr[31:ADDR_W+2] != '0);

  // Replace the addressed byte/half lane of a memory word with store data
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = old_w;
    if (sz == 2'b00) r[{off, 3'b000} +: 8] = wd[7:0];
    else             r[{off[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

  // Pick the addressed lane and extend to 32 bits
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef LSU_STATS_EN
  logic [STAT_W-1:0] stat_loads_q, stat_stores_q, stat_errs_q;
  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_lw_en_q <= 1'b0;
      mem_sw_en_q <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= '0;
`ifdef LSU_STATS_EN
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata;
            mem_addr_q  <= req_addr[ADDR_W+1:2];
            if (req_err_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (req_we && (req_size == 2'b10)) begin
              state_q     <= S_WRITE;
              mem_sw_en_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q     <= S_READ;
              mem_lw_en_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          // mem_rdata is the read buffer: consumed directly at the closing edge
          mem_lw_en_q <= 1'b0;
          if (we_q) begin
            state_q     <= S_WRITE;
            mem_sw_en_q <= 1'b1;
            mem_wdata_q <= merge_lane(mem_rdata, wdata_q, size_q, off_q);
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= extract(mem_rdata, size_q, off_q, uns_q);
          end
        end
        S_WRITE: begin
          mem_sw_en_q <= 1'b0;
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin // S_RESP
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_STATS_EN
            if (rsp_err_q) begin
              if (stat_errs_q != '1) stat_errs_q <= stat_errs_q + 1'b1;
            end else if (we_q) begin
              if (stat_stores_q != '1) stat_stores_q <= stat_stores_q + 1'b1;
            end else begin
              if (stat_loads_q != '1) stat_loads_q <= stat_loads_q + 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_lw_en = mem_lw_en_q;
  assign mem_sw_en = mem_sw_en_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a negedge-writing word memory model.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_lw_en, mem_sw_en;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lw_cnt   = 0;
  int sw_cnt   = 0;
  logic [7:0]  last_sw_addr  = '0;
  logic [31:0] last_sw_wdata = '0;
  logic [31:0] mem [256] = '{default: 32'h0};

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(8), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_lw_en(mem_lw_en), .mem_sw_en(mem_sw_en),
    .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // Data memory: combinational read, write on negedge while the write strobe is high
  assign mem_rdata = mem[mem_addr];

  always @(negedge clk) begin
    if (mem_sw_en) begin
      mem[mem_addr] <= mem_wdata;
      sw_cnt        <= sw_cnt + 1;
      last_sw_addr  <= mem_addr;
      last_sw_wdata <= mem_wdata;
    end
    if (mem_lw_en) lw_cnt <= lw_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for response (bounded), optionally stall, consume.
  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lw, input int exp_sw);
    int lw0, sw0, lat;
    logic [31:0] rd;
    logic er;
    lw0 = lw_cnt;
    sw0 = sw_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_hold_ready"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, er, exp_err);
    check({tag, "_lw"}, lw_cnt - lw0, exp_lw);
    check({tag, "_sw"}, sw_cnt - sw0, exp_sw);
    check({tag, "_done"}, rsp_valid, 1'b0);
    $display("txn %s we=%0d size=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d", tag, we, sz,
             addr, rd, er, lat);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err",   rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_lw_en",     mem_lw_en, 1'b0);
    check("rst_sw_en",     mem_sw_en, 1'b0);
    check("rst_mem_addr",  mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store and lane loads
    run("sw",  1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 0, 2, 32'h0, 0, 0, 1);
    check("sw_addr",  last_sw_addr, 32'h10);
    check("sw_wdata", last_sw_wdata, 32'hDEADBEEF);
    check("sw_mem",   mem[16], 32'hDEADBEEF);
    run("lb",  0, 2'b00, 0, 32'h43, 32'h0, 0, 2, 32'hFFFFFFDE, 0, 1, 0);
    run("lbu", 0, 2'b00, 1, 32'h43, 32'h0, 0, 2, 32'h000000DE, 0, 1, 0);
    run("lh",  0, 2'b01, 0, 32'h42, 32'h0, 0, 2, 32'hFFFFDEAD, 0, 1, 0);
    run("lhu", 0, 2'b01, 1, 32'h40, 32'h0, 0, 2, 32'h0000BEEF, 0, 1, 0);
    run("lw",  0, 2'b10, 1, 32'h40, 32'h0, 0, 2, 32'hDEADBEEF, 0, 1, 0);

    // Sub-word stores (read-modify-write)
    run("sb",  1, 2'b00, 0, 32'h41, 32'hFFFFFF12, 0, 3, 32'h0, 0, 1, 1);
    check("sb_wdata", last_sw_wdata, 32'hDEAD12EF);
    check("sb_mem",   mem[16], 32'hDEAD12EF);
    run("sh",  1, 2'b01, 0, 32'h42, 32'h1234CAFE, 0, 3, 32'h0, 0, 1, 1);
    check("sh_mem",   mem[16], 32'hCAFE12EF);

    // Top word of the memory is in range
    run("sw_top", 1, 2'b10, 0, 32'h3FC, 32'h12345678, 0, 2, 32'h0, 0, 0, 1);
    run("lw_top", 0, 2'b10, 0, 32'h3FC, 32'h0, 0, 2, 32'h12345678, 0, 1, 0);

    // Error requests: no strobes, one-cycle response
    run("e_lw_mis", 0, 2'b10, 0, 32'h42,  32'h0, 0, 1, 32'h0, 1, 0, 0);
    run("e_sh_mis", 1, 2'b01, 0, 32'h41,  32'hFFFF, 0, 1, 32'h0, 1, 0, 0);
    run("e_size",   0, 2'b11, 0, 32'h40,  32'h0, 0, 1, 32'h0, 1, 0, 0);
    run("e_range",  0, 2'b10, 0, 32'h400, 32'h0, 0, 1, 32'h0, 1, 0, 0);
    check("err_mem_unchanged", mem[16], 32'hCAFE12EF);

    // Backpressure on the response
    run("lb_hold", 0, 2'b00, 0, 32'h40, 32'h0, 5, 2, 32'hFFFFFFEF, 0, 1, 0);

    // Reset in the middle of a WRITE cycle, before its negedge
    begin
      int sw0;
      sw0 = sw_cnt;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h44;
      req_wdata = 32'h55555555;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("midrst_strobe_on", mem_sw_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_sw_drop", mem_sw_en, 1'b0);
      check("midrst_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      check("midrst_no_write", mem[17], 32'h0);
      check("midrst_sw_count", sw_cnt - sw0, 0);
      check("midrst_no_rsp", rsp_valid, 1'b0);
      $display("txn midrst addr=0x00000044 mem=0x%08h", mem[17]);
      @(negedge clk);
      rst_n = 1'b1;
    end

`ifdef LSU_STATS_EN
    run("st_l1", 0, 2'b10, 0, 32'h40, 32'h0, 0, 2, 32'hCAFE12EF, 0, 1, 0);
    run("st_l2", 0, 2'b00, 1, 32'h41, 32'h0, 0, 2, 32'h00000012, 0, 1, 0);
    run("st_s1", 1, 2'b10, 0, 32'h80, 32'hA5A5A5A5, 0, 2, 32'h0, 0, 0, 1);
    run("st_l3", 0, 2'b01, 0, 32'h42, 32'h0, 0, 2, 32'hFFFFCAFE, 0, 1, 0);
    run("st_s2", 1, 2'b00, 0, 32'h81, 32'h3C, 0, 3, 32'h0, 0, 1, 1);
    run("st_e1", 0, 2'b11, 0, 32'h40, 32'h0, 0, 1, 32'h0, 1, 0, 0);
    check("stat_loads",  stat_loads, 3);
    check("stat_stores", stat_stores, 2);
    check("stat_errs",   stat_errs, 1);
    check("stat_sb_mem", mem[32], 32'hA5A53CA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
